deadlock_kernel_monitor_param: RTL and testbench
================================================

Name: deadlock_kernel_monitor_param

Overview:
Parametrised kernel-level deadlock monitor for C/RTL co-simulation benches. It takes per-instance idle/stall status plus per-channel AXIS block flags from the generated DUT. It declares a kernel block only after the stuck condition has persisted for a programmable number of cycles. It exposes a registered block flag, a rise pulse, a sticky flag, the AXIS channel snapshot at first detection and a saturating episode counter, replacing the bench-side edge-detect/$display logic.

Parameters:
N_AXIS, 2, number of monitored AXIS channels
N_INST, 3, number of monitored process instances
N_BLK, 1, number of child-monitor block inputs
BLOCK_THRESH, 16, consecutive stuck cycles required to declare block (>=1)
CNT_W, 8, episode counter width
RUN_W, $clog2(BLOCK_THRESH+1), run-length counter width (derived, not overridden)

Ports:
kernel_monitor_clock  in  1  clock
kernel_monitor_reset  in  1  synchronous active-high reset
axis_block_sigs  in  N_AXIS  1 = AXIS channel waiting (blk_n low)
inst_idle_sigs  in  N_INST  1 = instance idle
inst_stall_sigs  in  N_INST  1 = instance stalled on any of its channels
inst_block_sigs  in  N_BLK  1 = child monitor reports block
clear  in  1  clears sticky/snapshot/counter
block  out  1  kernel block confirmed (level)
block_rise  out  1  one-cycle pulse on block 0->1
block_sticky  out  1  set on any block since reset/clear
axis_snapshot  out  N_AXIS  axis_block_sigs captured at first block
episode_cnt  out  CNT_W  number of block episodes, saturating
run_len  out  RUN_W  current consecutive stuck-cycle count

Behaviour:
- Reset (sync, active-high, sampled at kernel_monitor_clock rising edge): state IDLE; all outputs 0; run_len 0.
- Combinational raw stuck: raw = (&(inst_idle_sigs | inst_stall_sigs)) & ((|inst_stall_sigs) | (|inst_block_sigs)). All instances idle with no stall and no child block -> raw = 0 (normal completion is not a deadlock).
- FSM states IDLE, PENDING, BLOCKED:
  - IDLE: raw=1 -> run_len=1; if BLOCK_THRESH==1, go BLOCKED, else PENDING.
  - PENDING: raw=0 -> IDLE, run_len=0. raw=1 -> run_len+1; when the incremented value equals BLOCK_THRESH, go BLOCKED.
  - BLOCKED: raw=1 -> stay, run_len holds at BLOCK_THRESH. raw=0 -> IDLE, run_len=0.
- block = 1 exactly while in BLOCKED (registered). Latency: first block cycle is BLOCK_THRESH cycles after the first raw=1 cycle.
- block_rise = 1 for exactly the first BLOCKED cycle of each episode.
- On each entry to BLOCKED: episode_cnt increments, saturating at 2^CNT_W-1. If block_sticky was 0, axis_snapshot <= axis_block_sigs at that edge and block_sticky <= 1. Later episodes never overwrite the snapshot.
- clear (registered effect): block_sticky, axis_snapshot and episode_cnt go to 0; FSM, block and run_len are unaffected.
- clear coincident with entry to BLOCKED: entry wins. Result is sticky=1, snapshot captured, episode_cnt=1.
- Reset mid-episode: immediate return to IDLE; all outputs 0 next cycle.
- A raw glitch shorter than BLOCK_THRESH never asserts block or changes the counters.

Decomposition:
- Shared package deadlock_mon_pkg: FSM state enum (IDLE/PENDING/BLOCKED) and a helper function for the raw stuck reduction.
- One natural sub-module, deadlock_persist_fsm: the FSM plus run counter, taking raw and producing block and block_rise.
- Top level holds the snapshot, sticky flag and episode counter.

Test Plan:
- Reset, then all inputs 0 for 20 cycles -> block=0, episode_cnt=0, run_len=0.
- BLOCK_THRESH=16, inst_idle=3'b101, inst_stall=3'b010, axis=2'b01 held -> block rises exactly 16 cycles after stimulus; block_rise is a single pulse; axis_snapshot=2'b01; episode_cnt=1.
- raw high for 15 cycles, low for 1, high for 15 -> block never asserts; run_len returns to 0 during the gap.
- Two episodes, the second with axis=2'b10 -> snapshot stays 2'b01; episode_cnt=2; block_sticky stays 1 between episodes.
- CNT_W=2, five episodes -> episode_cnt saturates at 3. Then pulse clear -> sticky=0, snapshot=0, count=0. Then clear on the same edge as the next entry to BLOCKED -> count=1, sticky=1.
- Assert reset while in BLOCKED -> next cycle block=0, sticky=0, episode_cnt=0; the FSM restarts from IDLE and needs the full BLOCK_THRESH again.

Source files
------------

// File: rtl/deadlock_kernel_monitor_param_pkg.sv
// Shared types and helpers for the kernel deadlock monitor.
// Holds the persistence FSM state encoding and the raw stuck reduction.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_BLOCKED = 2'd2
  } mon_state_e;

  // Every instance idle-or-stalled, and at least one real reason to wait.
  // All-idle with nothing stalled is a normal finish, not a deadlock.
  function automatic logic raw_stuck(input logic all_settled,
                                     input logic any_stall,
                                     input logic any_child_block);
    return all_settled & (any_stall | any_child_block);
  endfunction

endpackage

// File: rtl/deadlock_kernel_monitor_param_if.sv
// Status inputs and monitor results bundled between a bench and the monitor.
interface deadlock_kernel_monitor_param_if #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 3,
  parameter int N_BLK  = 1,
  parameter int CNT_W  = 8,
  parameter int RUN_W  = 5
);
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_INST-1:0] inst_stall_sigs;
  logic [N_BLK-1:0]  inst_block_sigs;
  logic              clear;

  logic              block;
  logic              block_rise;
  logic              block_sticky;
  logic [N_AXIS-1:0] axis_snapshot;
  logic [CNT_W-1:0]  episode_cnt;
  logic [RUN_W-1:0]  run_len;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_stall_sigs, inst_block_sigs, clear,
    input  block, block_rise, block_sticky, axis_snapshot, episode_cnt, run_len
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_stall_sigs, inst_block_sigs, clear,
    output block, block_rise, block_sticky, axis_snapshot, episode_cnt, run_len
  );
endinterface

// File: rtl/deadlock_kernel_monitor_param_persist_fsm.sv
// Persistence filter: raw stuck must hold for BLOCK_THRESH consecutive cycles
// before block is declared; tracks the current run length.
module deadlock_persist_fsm
  import deadlock_mon_pkg::*;
#(
  parameter int BLOCK_THRESH = 16,
  parameter int RUN_W        = $clog2(BLOCK_THRESH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             raw,
  output logic             block,
  output logic             block_rise,
  output logic             enter_blocked,
  output logic [RUN_W-1:0] run_len
);
  localparam logic [RUN_W-1:0] THRESH_V = RUN_W'(BLOCK_THRESH);
  localparam logic [RUN_W-1:0] ONE_V    = RUN_W'(1);

  mon_state_e       state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic             rise_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_IDLE;
      run_reg   <= '0;
      rise_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      rise_reg  <= enter_blocked;
    end
  end

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (raw) begin
          run_next   = ONE_V;
          state_next = (BLOCK_THRESH == 1) ? ST_BLOCKED : ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!raw) begin
          state_next = ST_IDLE;
          run_next   = '0;
        end else begin
          run_next = run_reg + ONE_V;
          if (run_next == THRESH_V) state_next = ST_BLOCKED;
        end
      end
      ST_BLOCKED: begin
        if (!raw) begin
          state_next = ST_IDLE;
          run_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        run_next   = '0;
      end
    endcase
  end

  // Entry event is combinational so the top can capture at the same edge.
  assign enter_blocked = (state_next == ST_BLOCKED) && (state_reg != ST_BLOCKED);
  assign block         = (state_reg == ST_BLOCKED);
  assign block_rise    = rise_reg;
  assign run_len       = run_reg;

endmodule

// File: rtl/deadlock_kernel_monitor_param.sv
// Kernel-level deadlock monitor: raw stuck detection, persistence filter,
// sticky flag, first-episode AXIS snapshot and saturating episode counter.
module deadlock_kernel_monitor_param
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS       = 2,
  parameter int N_INST       = 3,
  parameter int N_BLK        = 1,
  parameter int BLOCK_THRESH = 16,
  parameter int CNT_W        = 8,
  localparam int RUN_W       = $clog2(BLOCK_THRESH + 1)
) (
  input logic                  kernel_monitor_clock,
  input logic                  kernel_monitor_reset,
  deadlock_kernel_monitor_param_if.slave mon
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_INST-1:0] inst_settled;
  logic              raw;
  logic              enter_blocked;
  logic              capture;
  logic              sticky_reg;
  logic [N_AXIS-1:0] snap_reg;
  logic [CNT_W-1:0]  cnt_reg;

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_settled
    assign inst_settled[gi] = mon.inst_idle_sigs[gi] | mon.inst_stall_sigs[gi];
  end

  assign raw = raw_stuck(&inst_settled, |mon.inst_stall_sigs, |mon.inst_block_sigs);

  deadlock_persist_fsm #(
    .BLOCK_THRESH (BLOCK_THRESH),
    .RUN_W        (RUN_W)
  ) u_fsm (
    .clk           (kernel_monitor_clock),
    .srst          (kernel_monitor_reset),
    .raw           (raw),
    .block         (mon.block),
    .block_rise    (mon.block_rise),
    .enter_blocked (enter_blocked),
    .run_len       (mon.run_len)
  );

  // A clear on the entry edge is overridden by the entry: count restarts at 1.
  assign capture = enter_blocked & (~sticky_reg | mon.clear);

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      sticky_reg <= 1'b0;
      snap_reg   <= '0;
      cnt_reg    <= '0;
    end else if (enter_blocked) begin
      sticky_reg <= 1'b1;
      if (capture) snap_reg <= mon.axis_block_sigs;
      if (mon.clear)               cnt_reg <= CNT_W'(1);
      else if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (mon.clear) begin
      sticky_reg <= 1'b0;
      snap_reg   <= '0;
      cnt_reg    <= '0;
    end
  end

  assign mon.block_sticky  = sticky_reg;
  assign mon.axis_snapshot = snap_reg;
  assign mon.episode_cnt   = cnt_reg;

endmodule

// File: tb/tb_deadlock_kernel_monitor_param.sv
// Bench for the kernel deadlock monitor: two instances (threshold 16 / 2-bit
// counter, and threshold 1 / 8-bit counter) against a streak-count model.
module tb_deadlock_kernel_monitor_param;
  logic       clk = 1'b0;
  logic       rst_v = 1'b1;
  logic [2:0] idle_v = '0;
  logic [2:0] stall_v = '0;
  logic [0:0] blk_v = '0;
  logic [1:0] axis_v = '0;
  logic       clr_v = 1'b0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  deadlock_kernel_monitor_param_if #(.N_AXIS(2), .N_INST(3), .N_BLK(1), .CNT_W(2), .RUN_W(5)) bus_a ();
  deadlock_kernel_monitor_param_if #(.N_AXIS(2), .N_INST(3), .N_BLK(1), .CNT_W(8), .RUN_W(1)) bus_b ();

  assign bus_a.axis_block_sigs = axis_v;
  assign bus_a.inst_idle_sigs  = idle_v;
  assign bus_a.inst_stall_sigs = stall_v;
  assign bus_a.inst_block_sigs = blk_v;
  assign bus_a.clear           = clr_v;
  assign bus_b.axis_block_sigs = axis_v;
  assign bus_b.inst_idle_sigs  = idle_v;
  assign bus_b.inst_stall_sigs = stall_v;
  assign bus_b.inst_block_sigs = blk_v;
  assign bus_b.clear           = clr_v;

  deadlock_kernel_monitor_param #(.N_AXIS(2), .N_INST(3), .N_BLK(1), .BLOCK_THRESH(16), .CNT_W(2)) dut_a (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst_v),
    .mon                  (bus_a)
  );

  deadlock_kernel_monitor_param #(.N_AXIS(2), .N_INST(3), .N_BLK(1), .BLOCK_THRESH(1), .CNT_W(8)) dut_b (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst_v),
    .mon                  (bus_b)
  );

  // Model: block means raw has been high for at least thr consecutive cycles.
  int m_thr[2]  = '{16, 1};
  int m_cmax[2] = '{3, 255};
  int m_streak[2], m_snap[2], m_cnt[2];
  bit m_block[2], m_rise[2], m_sticky[2];

  function automatic bit model_raw(logic [2:0] idle, logic [2:0] stall, logic [0:0] blk);
    bit all_ok = 1'b1;
    bit reason = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!(idle[i] || stall[i])) all_ok = 1'b0;
      if (stall[i]) reason = 1'b1;
    end
    if (blk != 0) reason = 1'b1;
    return all_ok && reason;
  endfunction

  initial forever begin
    @(posedge clk);
    begin
      bit r;
      bit nb;
      r = model_raw(idle_v, stall_v, blk_v);
      for (int k = 0; k < 2; k++) begin
        if (rst_v) begin
          m_streak[k] = 0; m_block[k] = 0; m_rise[k] = 0;
          m_sticky[k] = 0; m_snap[k] = 0;  m_cnt[k] = 0;
        end else begin
          if (!r) m_streak[k] = 0;
          else if (m_streak[k] < m_thr[k]) m_streak[k]++;
          nb = (m_streak[k] == m_thr[k]);
          m_rise[k]  = nb && !m_block[k];
          m_block[k] = nb;
          if (clr_v) begin
            m_sticky[k] = 0; m_snap[k] = 0; m_cnt[k] = 0;
          end
          if (m_rise[k]) begin
            if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
            if (!m_sticky[k]) begin
              m_snap[k] = int'(axis_v);
              m_sticky[k] = 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("a_block",  int'(bus_a.block),         int'(m_block[0]));
      chk("a_rise",   int'(bus_a.block_rise),    int'(m_rise[0]));
      chk("a_sticky", int'(bus_a.block_sticky),  int'(m_sticky[0]));
      chk("a_snap",   int'(bus_a.axis_snapshot), m_snap[0]);
      chk("a_cnt",    int'(bus_a.episode_cnt),   m_cnt[0]);
      chk("a_run",    int'(bus_a.run_len),       m_streak[0]);
      chk("b_block",  int'(bus_b.block),         int'(m_block[1]));
      chk("b_rise",   int'(bus_b.block_rise),    int'(m_rise[1]));
      chk("b_sticky", int'(bus_b.block_sticky),  int'(m_sticky[1]));
      chk("b_snap",   int'(bus_b.axis_snapshot), m_snap[1]);
      chk("b_cnt",    int'(bus_b.episode_cnt),   m_cnt[1]);
      chk("b_run",    int'(bus_b.run_len),       m_streak[1]);
    end
  end

  task automatic step(logic [2:0] idle, logic [2:0] stall, logic [0:0] blk,
                      logic [1:0] axis, logic clr, logic rst);
    idle_v = idle; stall_v = stall; blk_v = blk; axis_v = axis; clr_v = clr; rst_v = rst;
    @(negedge clk);
    #1;
  endtask

  task automatic stuck(int n, logic [1:0] axis);
    for (int i = 0; i < n; i++) step(3'b101, 3'b010, 1'b0, axis, 1'b0, 1'b0);
  endtask

  task automatic quiet(int n);
    for (int i = 0; i < n; i++) step(3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1);
    chk_en = 1'b1;
    quiet(20);
    chk("idle_block", int'(bus_a.block), 0);
    chk("idle_cnt", int'(bus_a.episode_cnt), 0);
    chk("idle_run", int'(bus_a.run_len), 0);
    $display("txn idle20: block=%0d cnt=%0d", bus_a.block, bus_a.episode_cnt);

    stuck(15, 2'b01);
    chk("lat15_block", int'(bus_a.block), 0);
    stuck(1, 2'b01);
    chk("lat16_block", int'(bus_a.block), 1);
    chk("lat16_rise", int'(bus_a.block_rise), 1);
    chk("lat16_snap", int'(bus_a.axis_snapshot), 1);
    chk("lat16_cnt", int'(bus_a.episode_cnt), 1);
    stuck(1, 2'b01);
    chk("rise_once", int'(bus_a.block_rise), 0);
    chk("run_hold", int'(bus_a.run_len), 16);
    $display("txn first_block: snap=%b cnt=%0d", bus_a.axis_snapshot, bus_a.episode_cnt);

    quiet(2);
    stuck(15, 2'b11);
    quiet(1);
    chk("gap_run", int'(bus_a.run_len), 0);
    stuck(15, 2'b11);
    chk("glitch_block", int'(bus_a.block), 0);
    chk("glitch_cnt", int'(bus_a.episode_cnt), 1);
    $display("txn glitch: block=%0d run=%0d", bus_a.block, bus_a.run_len);

    quiet(1);
    chk("between_sticky", int'(bus_a.block_sticky), 1);
    stuck(16, 2'b10);
    chk("ep2_cnt", int'(bus_a.episode_cnt), 2);
    chk("ep2_snap", int'(bus_a.axis_snapshot), 1);
    $display("txn episode2: snap=%b cnt=%0d", bus_a.axis_snapshot, bus_a.episode_cnt);

    for (int e = 0; e < 3; e++) begin
      quiet(1);
      stuck(16, 2'b10);
    end
    chk("sat_cnt", int'(bus_a.episode_cnt), 3);
    quiet(1);
    step(3'b000, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("clr_sticky", int'(bus_a.block_sticky), 0);
    chk("clr_snap", int'(bus_a.axis_snapshot), 0);
    chk("clr_cnt", int'(bus_a.episode_cnt), 0);
    $display("txn saturate+clear: cnt=%0d sticky=%0d", bus_a.episode_cnt, bus_a.block_sticky);

    stuck(15, 2'b11);
    step(3'b101, 3'b010, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("clrwin_cnt", int'(bus_a.episode_cnt), 1);
    chk("clrwin_sticky", int'(bus_a.block_sticky), 1);
    chk("clrwin_snap", int'(bus_a.axis_snapshot), 3);
    $display("txn clear_vs_entry: cnt=%0d snap=%b", bus_a.episode_cnt, bus_a.axis_snapshot);

    stuck(2, 2'b11);
    step(3'b101, 3'b010, 1'b0, 2'b11, 1'b0, 1'b1);
    chk("rst_block", int'(bus_a.block), 0);
    chk("rst_sticky", int'(bus_a.block_sticky), 0);
    chk("rst_cnt", int'(bus_a.episode_cnt), 0);
    stuck(15, 2'b01);
    chk("rst_relat15", int'(bus_a.block), 0);
    stuck(1, 2'b01);
    chk("rst_relat16", int'(bus_a.block), 1);
    $display("txn reset_mid_block: block=%0d cnt=%0d", bus_a.block, bus_a.episode_cnt);

    // Random: alternate stuck bursts of random length with arbitrary traffic.
    for (int b = 0; b < 200; b++) begin
      int len;
      bit stuck_mode;
      len = int'($urandom_range(1, 24));
      stuck_mode = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < len; i++) begin
        logic [2:0] id, st;
        logic [0:0] bk;
        id = 3'($urandom);
        if (stuck_mode) begin
          st = ~id | 3'($urandom);
          bk = 1'($urandom);
          if (st == 3'b000 && bk == 1'b0) bk = 1'b1;
        end else begin
          st = 3'($urandom);
          bk = 1'($urandom);
        end
        step(id, st, bk, 2'($urandom), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 499) == 0));
      end
    end
    $display("txn random: 200 bursts done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
